// File: rtl/round_match_scheduler_pkg.sv
// Shared encodings for the round/match scheduler: FSM states, round result codes,
// health width and the KO decision helper.
package round_pkg;

  localparam int HEALTH_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ROUND        = 3'd1,
    ST_ROUND_END    = 3'd2,
    ST_MATCH_OVER   = 3'd3,
    ST_SUDDEN_DEATH = 3'd4
  } round_state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_P1   = 2'd1,
    RES_P2   = 2'd2,
    RES_DRAW = 2'd3
  } round_result_e;

  // A knocked-out player loses; both down at once is a draw.
  function automatic round_result_e ko_result(input logic [HEALTH_W-1:0] h1,
                                              input logic [HEALTH_W-1:0] h2);
    round_result_e res;
    if ((h1 == {HEALTH_W{1'b0}}) && (h2 == {HEALTH_W{1'b0}})) begin
      res = RES_DRAW;
    end else if (h1 == {HEALTH_W{1'b0}}) begin
      res = RES_P2;
    end else if (h2 == {HEALTH_W{1'b0}}) begin
      res = RES_P1;
    end else begin
      res = RES_NONE;
    end
    return res;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/round_match_scheduler_timer.sv
// Round clock: ticks-per-second prescaler feeding a seconds down-counter that
// parks at 0:0 and flags expiry on the enabled tick spent there.
module round_timer #(
  parameter int TICKS_PER_SEC = 60,
  parameter int ROUND_SECONDS = 60
) (
  input  logic       clk_game,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  output logic [7:0] round_time_sec,
  output logic       expire
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0] SEC_LOAD = 8'(ROUND_SECONDS);

  logic [TICK_W-1:0] tick_cnt_r;
  logic [7:0]        sec_r;
  logic              at_zero_s;

  assign at_zero_s      = (tick_cnt_r == {TICK_W{1'b0}}) && (sec_r == 8'd0);
  assign expire         = enable && at_zero_s;
  assign round_time_sec = sec_r;

  // Prescaler and seconds counter; load wins over counting
  always_ff @(posedge clk_game) begin
    if (reset || load) begin
      tick_cnt_r <= TICK_MAX;
      sec_r      <= SEC_LOAD;
    end else if (enable && !at_zero_s) begin
      if (tick_cnt_r == {TICK_W{1'b0}}) begin
        tick_cnt_r <= TICK_MAX;
        sec_r      <= sec_r - 8'd1;
      end else begin
        tick_cnt_r <= tick_cnt_r - TICK_W'(1);
      end
    end else begin
      tick_cnt_r <= tick_cnt_r;
      sec_r      <= sec_r;
    end
  end

endmodule

// File: rtl/round_match_scheduler.sv
// Best-of-N match sequencer: round start, timer, winner decision, intermission, match end.
// Define ROUND_SUDDEN_DEATH_EN to turn equal-health timeouts into a sudden-death phase.
module round_match_scheduler
  import round_pkg::*;
#(
  parameter int TICKS_PER_SEC      = 60,
  parameter int ROUND_SECONDS      = 60,
  parameter int WINS_TO_MATCH      = 2,
  parameter int MAX_ROUNDS         = 5,
  parameter int INTERMISSION_TICKS = 120
) (
  input  logic                clk_game,
  input  logic                reset,
  input  logic                reset_gameplay,
  input  logic                start_gameplay,
  input  logic                timer_enable,
  input  logic [HEALTH_W-1:0] p1_health,
  input  logic [HEALTH_W-1:0] p2_health,
  output logic                round_active,
  output logic                intermission,
  output logic                respawn_players,
  output logic [2:0]          round_number,
  output logic [7:0]          round_time_sec,
  output logic [1:0]          p1_wins,
  output logic [1:0]          p2_wins,
  output logic [1:0]          last_result,
  output logic                game_over_condition,
  output logic                winner_p1,
  output logic                winner_p2
);

  localparam int INT_W = $clog2(INTERMISSION_TICKS + 1);
  localparam logic [INT_W-1:0] INT_LOAD = INT_W'(INTERMISSION_TICKS - 1);
  localparam logic [2:0] MAX_RND = 3'(MAX_ROUNDS);
  localparam logic [1:0] WIN_TGT = 2'(WINS_TO_MATCH);

  round_state_e  state_r;
  logic [INT_W-1:0] inter_cnt_r;
  round_result_e decide_s;
  logic          go_sd_s;
  logic          match_done_s;
  logic          next_round_s;
  logic          timer_load_s;
  logic          timer_en_s;
  logic          expire_s;

  round_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .ROUND_SECONDS(ROUND_SECONDS)
  ) u_timer (
    .clk_game      (clk_game),
    .reset         (reset),
    .load          (timer_load_s),
    .enable        (timer_en_s),
    .round_time_sec(round_time_sec),
    .expire        (expire_s)
  );

  // Per-cycle round decision and timer control
  always_comb begin
    decide_s     = RES_NONE;
    go_sd_s      = 1'b0;
    match_done_s = (p1_wins == WIN_TGT) || (p2_wins == WIN_TGT) || (round_number == MAX_RND);
    next_round_s = (state_r == ST_ROUND_END) && (inter_cnt_r == {INT_W{1'b0}}) && !match_done_s;
    timer_load_s = reset_gameplay || ((state_r == ST_IDLE) && start_gameplay) || next_round_s;
    timer_en_s   = timer_enable && (state_r == ST_ROUND);
    // A KO always outranks a timeout landing on the same tick
    if (ko_result(p1_health, p2_health) != RES_NONE) begin
      decide_s = ko_result(p1_health, p2_health);
    end else if (expire_s) begin
      if (p1_health > p2_health) begin
        decide_s = RES_P1;
      end else if (p2_health > p1_health) begin
        decide_s = RES_P2;
      end else begin
`ifdef ROUND_SUDDEN_DEATH_EN
        decide_s = RES_NONE;
        go_sd_s  = 1'b1;
`else
        decide_s = RES_DRAW;
`endif
      end
    end else begin
      decide_s = RES_NONE;
    end
  end

  // Match FSM with registered status outputs
  always_ff @(posedge clk_game) begin
    if (reset || reset_gameplay) begin
      state_r             <= ST_IDLE;
      inter_cnt_r         <= {INT_W{1'b0}};
      round_active        <= 1'b0;
      intermission        <= 1'b0;
      respawn_players     <= 1'b0;
      round_number        <= 3'd0;
      p1_wins             <= 2'd0;
      p2_wins             <= 2'd0;
      last_result         <= RES_NONE;
      game_over_condition <= 1'b0;
      winner_p1           <= 1'b0;
      winner_p2           <= 1'b0;
    end else begin
      respawn_players <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_gameplay) begin
            state_r         <= ST_ROUND;
            round_active    <= 1'b1;
            respawn_players <= 1'b1;
            round_number    <= 3'd1;
            p1_wins         <= 2'd0;
            p2_wins         <= 2'd0;
            last_result     <= RES_NONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ROUND, ST_SUDDEN_DEATH: begin
          if (decide_s != RES_NONE) begin
            state_r      <= ST_ROUND_END;
            round_active <= 1'b0;
            intermission <= 1'b1;
            inter_cnt_r  <= INT_LOAD;
            last_result  <= decide_s;
            if (decide_s == RES_P1) begin
              p1_wins <= sat_inc2(p1_wins);
            end else if (decide_s == RES_P2) begin
              p2_wins <= sat_inc2(p2_wins);
            end else begin
              p1_wins <= p1_wins;
            end
          end else if (go_sd_s) begin
            state_r <= ST_SUDDEN_DEATH;
          end else begin
            state_r <= state_r;
          end
        end
        ST_ROUND_END: begin
          if (inter_cnt_r != {INT_W{1'b0}}) begin
            inter_cnt_r <= inter_cnt_r - INT_W'(1);
          end else if (match_done_s) begin
            state_r             <= ST_MATCH_OVER;
            intermission        <= 1'b0;
            game_over_condition <= 1'b1;
            winner_p1           <= (p1_wins > p2_wins);
            winner_p2           <= (p2_wins > p1_wins);
          end else begin
            state_r         <= ST_ROUND;
            intermission    <= 1'b0;
            round_active    <= 1'b1;
            respawn_players <= 1'b1;
            round_number    <= round_number + 3'd1;
          end
        end
        ST_MATCH_OVER: begin
          state_r <= ST_MATCH_OVER;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_match_scheduler.sv
// Self-checking bench for round_match_scheduler: randomized healths, pauses and KO timing
// checked against an abstract rule model and an integer win scoreboard.
`timescale 1ns/1ps
module tb_round_match_scheduler;

  localparam int TPS   = 2;
  localparam int RS    = 2;
  localparam int WTM   = 2;
  localparam int MAXR  = 3;
  localparam int INTER = 120;
  localparam int TIMEOUT_TICKS = RS * TPS + TPS;

  logic       clk_game = 1'b0;
  logic       reset = 1'b1;
  logic       reset_gameplay = 1'b0;
  logic       start_gameplay = 1'b0;
  logic       timer_enable = 1'b0;
  logic [6:0] p1_health = 7'd100;
  logic [6:0] p2_health = 7'd100;
  logic       round_active, intermission, respawn_players;
  logic [2:0] round_number;
  logic [7:0] round_time_sec;
  logic [1:0] p1_wins, p2_wins, last_result;
  logic       game_over_condition, winner_p1, winner_p2;

  int errors = 0;
  int checks = 0;

  always #5 clk_game = ~clk_game;

  round_match_scheduler #(
    .TICKS_PER_SEC(TPS), .ROUND_SECONDS(RS), .WINS_TO_MATCH(WTM),
    .MAX_ROUNDS(MAXR), .INTERMISSION_TICKS(INTER)
  ) dut (
    .clk_game(clk_game), .reset(reset), .reset_gameplay(reset_gameplay),
    .start_gameplay(start_gameplay), .timer_enable(timer_enable),
    .p1_health(p1_health), .p2_health(p2_health),
    .round_active(round_active), .intermission(intermission),
    .respawn_players(respawn_players), .round_number(round_number),
    .round_time_sec(round_time_sec), .p1_wins(p1_wins), .p2_wins(p2_wins),
    .last_result(last_result), .game_over_condition(game_over_condition),
    .winner_p1(winner_p1), .winner_p2(winner_p2)
  );

  // Reference rule: returns the round outcome, 0 meaning the round carries on
  function automatic logic [1:0] ref_decide(input int h1, input int h2, input bit timeout);
    if (h1 == 0 && h2 == 0) return 2'd3;
    if (h1 == 0) return 2'd2;
    if (h2 == 0) return 2'd1;
    if (!timeout) return 2'd0;
    if (h1 > h2) return 2'd1;
    if (h2 > h1) return 2'd2;
`ifdef ROUND_SUDDEN_DEATH_EN
    return 2'd0;
`else
    return 2'd3;
`endif
  endfunction

  function automatic logic [14:0] status();
    return {round_active, intermission, respawn_players, round_number, p1_wins, p2_wins,
            last_result, game_over_condition, winner_p1, winner_p2};
  endfunction

  task automatic step();
    @(posedge clk_game);
    #1;
  endtask

  // Fresh match from IDLE; leaves the bench in the first ROUND cycle
  task automatic begin_match();
    reset_gameplay = 1'b1; step(); reset_gameplay = 1'b0;
    start_gameplay = 1'b1; step(); start_gameplay = 1'b0;
    checks++; if (respawn_players !== 1'b1 || round_active !== 1'b1) begin errors++; $display("FAIL start_round: respawn=%b active=%b want 1 1", respawn_players, round_active); end
    checks++; if (round_number !== 3'd1 || round_time_sec !== 8'(RS)) begin errors++; $display("FAIL start_load: round=%0d time=%0d want 1 %0d", round_number, round_time_sec, RS); end
  endtask

  // Runs ROUND cycles: timer paused for cycles [3,3+pause), health zeroed at cycle ko_at
  task automatic run_round(input int pause, input int ko_at, input bit z1, input bit z2,
                           input int budget, output int c);
    c = 1;
    while (round_active === 1'b1 && c < budget) begin
      timer_enable = !(c >= 3 && c < 3 + pause);
      if (c == ko_at) begin
        if (z1) p1_health = 7'd0;
        if (z2) p2_health = 7'd0;
      end
      step();
      if (round_active === 1'b1) c++;
    end
  endtask

  // Counts ROUND_END cycles while scribbling on health, then restores h1/h2
  task automatic run_intermission(input logic [6:0] h1, input logic [6:0] h2, output int n);
    n = 1;
    p1_health = 7'd0; p2_health = 7'd0;
    while (n < 200) begin
      if (n == 50) begin p1_health = h1; p2_health = h2; end
      step();
      if (intermission === 1'b1) n++;
      else break;
    end
    p1_health = h1; p2_health = h2;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_gameplay = 1'b1; reset_gameplay = 1'b1;
    step(); step();
    checks++; if (status() !== 15'd0) begin errors++; $display("FAIL reset_outputs: got %b want 0", status()); end
    checks++; if (round_time_sec !== 8'(RS)) begin errors++; $display("FAIL reset_time: got %0d want %0d", round_time_sec, RS); end
    reset = 1'b0; start_gameplay = 1'b0; reset_gameplay = 1'b0;
    step();
    checks++; if (status() !== 15'd0) begin errors++; $display("FAIL reset_idle_hold: got %b want 0", status()); end
  endtask

  task automatic test_ko_and_two_zero();
    logic [6:0] h1, h2;
    int c, n, ko2;
    h1 = 7'($urandom_range(1, 127)); h2 = 7'($urandom_range(1, 127));
    p1_health = h1; p2_health = h2;
    begin_match();
    run_round(1000, 10, 1'b0, 1'b1, 100, c);
    checks++; if (c !== 10) begin errors++; $display("FAIL ko_round_len: got %0d want 10", c); end
    checks++; if (intermission !== 1'b1 || last_result !== ref_decide(h1, 0, 1'b0) || p1_wins !== 2'd1 || p2_wins !== 2'd0) begin
      errors++; $display("FAIL ko_result: int=%b res=%0d w=%0d/%0d want 1 1 1/0", intermission, last_result, p1_wins, p2_wins); end
    run_intermission(h1, h2, n);
    checks++; if (n !== INTER) begin errors++; $display("FAIL ko_intermission: got %0d want %0d", n, INTER); end
    checks++; if (respawn_players !== 1'b1 || round_number !== 3'd2 || round_active !== 1'b1 || round_time_sec !== 8'(RS)) begin
      errors++; $display("FAIL ko_round2: resp=%b round=%0d active=%b time=%0d", respawn_players, round_number, round_active, round_time_sec); end
    ko2 = $urandom_range(2, 8);
    run_round(1000, ko2, 1'b0, 1'b1, 100, c);
    checks++; if (c !== ko2 || p1_wins !== 2'd2) begin errors++; $display("FAIL ko2: len=%0d wins=%0d want %0d 2", c, p1_wins, ko2); end
    run_intermission(h1, h2, n);
    checks++; if (n !== INTER) begin errors++; $display("FAIL ko2_intermission: got %0d want %0d", n, INTER); end
    checks++; if (game_over_condition !== 1'b1 || winner_p1 !== 1'b1 || winner_p2 !== 1'b0 || round_active !== 1'b0) begin
      errors++; $display("FAIL match_2_0: go=%b w1=%b w2=%b act=%b want 1 1 0 0", game_over_condition, winner_p1, winner_p2, round_active); end
    start_gameplay = 1'b1; step(); start_gameplay = 1'b0; step(); step();
    checks++; if (game_over_condition !== 1'b1 || round_active !== 1'b0 || respawn_players !== 1'b0) begin
      errors++; $display("FAIL match_over_hold: go=%b act=%b resp=%b", game_over_condition, round_active, respawn_players); end
    reset_gameplay = 1'b1; step(); reset_gameplay = 1'b0;
    checks++; if (status() !== 15'd0 || round_time_sec !== 8'(RS)) begin errors++; $display("FAIL reset_gameplay_idle: got %b time=%0d want 0 %0d", status(), round_time_sec, RS); end
  endtask

  task automatic test_timeout(input int pause);
    logic [6:0] h1, h2;
    logic [1:0] exp;
    int c;
    h1 = 7'($urandom_range(1, 127));
    do h2 = 7'($urandom_range(1, 127)); while (h2 == h1);
    p1_health = h1; p2_health = h2;
    exp = ref_decide(h1, h2, 1'b1);
    begin_match();
    run_round(pause, 0, 1'b0, 1'b0, 100, c);
    checks++; if (c !== TIMEOUT_TICKS + pause) begin errors++; $display("FAIL timeout_len(p=%0d): got %0d want %0d", pause, c, TIMEOUT_TICKS + pause); end
    checks++; if (intermission !== 1'b1 || last_result !== exp || p1_wins !== 2'(exp == 2'd1) || p2_wins !== 2'(exp == 2'd2)) begin
      errors++; $display("FAIL timeout_result: res=%0d w=%0d/%0d want %0d", last_result, p1_wins, p2_wins, exp); end
  endtask

  task automatic test_ko_at_timeout(input bit both);
    int c;
    p1_health = 7'd90; p2_health = 7'd10;
    begin_match();
    run_round(0, TIMEOUT_TICKS, 1'b1, both, 100, c);
    checks++; if (c !== TIMEOUT_TICKS) begin errors++; $display("FAIL ko_timeout_len: got %0d want %0d", c, TIMEOUT_TICKS); end
    checks++; if (last_result !== ref_decide(0, both ? 0 : 10, 1'b1) || p1_wins !== 2'd0 || p2_wins !== 2'(!both)) begin
      errors++; $display("FAIL ko_timeout_result(both=%0d): res=%0d w=%0d/%0d", both, last_result, p1_wins, p2_wins); end
  endtask

  task automatic test_draws_max_rounds();
    int c, n;
    p1_health = 7'd60; p2_health = 7'd70;
    begin_match();
    for (int r = 1; r <= MAXR; r++) begin
      run_round(0, 1, 1'b1, 1'b1, 100, c);
      checks++; if (last_result !== 2'd3 || p1_wins !== 2'd0 || p2_wins !== 2'd0) begin errors++; $display("FAIL draw_round%0d: res=%0d w=%0d/%0d want 3 0/0", r, last_result, p1_wins, p2_wins); end
      run_intermission(7'd60, 7'd70, n);
      if (r < MAXR) begin
        checks++; if (respawn_players !== 1'b1 || round_number !== 3'(r + 1)) begin errors++; $display("FAIL draw_next%0d: resp=%b round=%0d", r, respawn_players, round_number); end
      end else begin
        checks++; if (game_over_condition !== 1'b1 || winner_p1 !== 1'b0 || winner_p2 !== 1'b0 || round_number !== 3'(MAXR)) begin
          errors++; $display("FAIL max_rounds: go=%b w1=%b w2=%b round=%0d want 1 0 0 %0d", game_over_condition, winner_p1, winner_p2, round_number, MAXR); end
      end
    end
  endtask

  task automatic test_equal_timeout();
    logic [6:0] h;
    int c;
    h = 7'($urandom_range(1, 127));
    p1_health = h; p2_health = h;
    begin_match();
`ifdef ROUND_SUDDEN_DEATH_EN
    run_round(0, 0, 1'b0, 1'b0, TIMEOUT_TICKS + $urandom_range(3, 20), c);
    checks++; if (round_active !== 1'b1 || intermission !== 1'b0 || round_time_sec !== 8'd0 || last_result !== 2'd0) begin
      errors++; $display("FAIL sudden_death_hold: act=%b int=%b time=%0d res=%0d", round_active, intermission, round_time_sec, last_result); end
    p1_health = 7'd0; step();
    checks++; if (intermission !== 1'b1 || last_result !== ref_decide(0, h, 1'b0) || p2_wins !== 2'd1) begin
      errors++; $display("FAIL sudden_death_ko: int=%b res=%0d p2w=%0d want 1 2 1", intermission, last_result, p2_wins); end
`else
    run_round(0, 0, 1'b0, 1'b0, 100, c);
    checks++; if (c !== TIMEOUT_TICKS || last_result !== ref_decide(h, h, 1'b1) || p1_wins !== 2'd0 || p2_wins !== 2'd0) begin
      errors++; $display("FAIL equal_timeout: len=%0d res=%0d w=%0d/%0d want %0d 3 0/0", c, last_result, p1_wins, p2_wins, TIMEOUT_TICKS); end
`endif
  endtask

  task automatic test_midround_reset();
    int c;
    p1_health = 7'd50; p2_health = 7'd50;
    begin_match();
    run_round(1000, 0, 1'b0, 1'b0, $urandom_range(2, 6), c);
    reset_gameplay = 1'b1; start_gameplay = 1'b1; step();
    reset_gameplay = 1'b0; start_gameplay = 1'b0;
    checks++; if (status() !== 15'd0) begin errors++; $display("FAIL midround_reset: got %b want 0", status()); end
    step();
    checks++; if (round_active !== 1'b0 || respawn_players !== 1'b0) begin errors++; $display("FAIL midround_idle: act=%b resp=%b want 0 0", round_active, respawn_players); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ko_and_two_zero();
    test_timeout(0);
    test_timeout(5);
    test_timeout($urandom_range(1, 9));
    test_ko_at_timeout(1'b1);
    test_ko_at_timeout(1'b0);
    test_draws_max_rounds();
    test_equal_timeout();
    test_midround_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_match_scheduler.md
Name: round_match_scheduler

Overview:
- Sequences a best-of-N match inside the gameplay phase. It runs round start, round timer, round-winner decision, intermission and match end.
- Sits between the game state controller and the gameplay/health logic.
- Consumes start_gameplay, reset_gameplay and timer_enable. Produces game_over_condition, winner_p1 and winner_p2 back to the game state controller, and respawn pulses to the gameplay modules.

Parameters:
- TICKS_PER_SEC, 60, clk_game ticks per displayed second
- ROUND_SECONDS, 60, round duration in seconds (1..255)
- WINS_TO_MATCH, 2, round wins needed to take the match (1..3)
- MAX_ROUNDS, 5, hard round cap (WINS_TO_MATCH..7)
- INTERMISSION_TICKS, 120, ROUND_END dwell in ticks (>=1)

Ports:
- clk_game  in  1  60Hz game clock
- reset  in  1  synchronous active-high reset
- reset_gameplay  in  1  level; forces IDLE and clears match
- start_gameplay  in  1  one-cycle pulse; begins the match
- timer_enable  in  1  round timer counts only while high (pause otherwise)
- p1_health  in  7  current P1 health; 0 = KO
- p2_health  in  7  current P2 health; 0 = KO
- round_active  out  1  high in ROUND state
- intermission  out  1  high in ROUND_END state
- respawn_players  out  1  one-cycle pulse on every ROUND entry
- round_number  out  3  current round, 1-based; 0 in IDLE
- round_time_sec  out  8  seconds remaining in round
- p1_wins  out  2  rounds won by P1
- p2_wins  out  2  rounds won by P2
- last_result  out  2  0 none, 1 P1, 2 P2, 3 draw
- game_over_condition  out  1  high throughout MATCH_OVER
- winner_p1  out  1  valid while game_over_condition is high
- winner_p2  out  1  valid while game_over_condition is high

Behaviour:
- Clock and reset: single clock clk_game. reset is synchronous and active-high. Reset priority: reset > reset_gameplay > all other events.
- Reset values: state IDLE; every output 0, except round_time_sec = ROUND_SECONDS.
- IDLE: start_gameplay moves to ROUND on the next edge. round_number = 1, wins cleared, timer loaded, respawn_players = 1 for exactly that first ROUND cycle. start_gameplay outside IDLE is ignored.
- Round timer:
  - tick_cnt counts TICKS_PER_SEC-1 down to 0, only while timer_enable = 1 and state = ROUND.
  - When tick_cnt wraps, round_time_sec decrements.
  - Timeout fires on the tick where round_time_sec = 0 and tick_cnt = 0. round_time_sec never underflows.
  - Timeout therefore takes ROUND_SECONDS*TICKS_PER_SEC + TICKS_PER_SEC enabled ticks.
- ROUND decision, evaluated each cycle in priority order:
  - Both health values = 0: draw.
  - p1_health = 0: P2 wins.
  - p2_health = 0: P1 wins.
  - Timeout: higher health wins; equal health is a draw.
- ROUND to ROUND_END: on any decision, last_result is registered, the winner's counter increments (saturating at 3), and the state becomes ROUND_END the next cycle. A KO outranks a timeout in the same cycle.
- ROUND_END:
  - Waits INTERMISSION_TICKS; counting ignores timer_enable.
  - Then goes to MATCH_OVER if p1_wins or p2_wins equals WINS_TO_MATCH, or if round_number equals MAX_ROUNDS.
  - Otherwise goes to ROUND: round_number+1, timer reloaded, respawn pulse.
- MATCH_OVER:
  - game_over_condition = 1.
  - winner_p1 = (p1_wins > p2_wins); winner_p2 = (p2_wins > p1_wins). Equal wins gives both 0 (draw).
  - Holds until reset_gameplay, which moves to IDLE.
- reset_gameplay mid-operation: next state IDLE, counters and results cleared, no respawn pulse.
- Health is sampled only in ROUND. Health changes during ROUND_END are ignored.

Optional Feature:
- Macro: ROUND_SUDDEN_DEATH_EN.
- Defined: a timeout with equal health does not end the round. The block enters a SUDDEN_DEATH state: round_active stays 1, round_time_sec holds 0, the timer stops, and the first KO decides the round with the same KO rules as ROUND.
- Not defined: equal-health timeout is a draw and the SUDDEN_DEATH state is absent.

Decomposition:
- Package round_pkg holds:
  - state encodings (IDLE, ROUND, ROUND_END, MATCH_OVER, SUDDEN_DEATH)
  - result codes RES_NONE/RES_P1/RES_P2/RES_DRAW
  - health width constant (7)
- Sub-module round_timer: tick/second down-counter with load, enable and expire-pulse outputs. It is instantiated once.

Test Plan:
- KO: start_gameplay, then after 10 cycles p2_health = 0 -> last_result = 1, p1_wins = 1, intermission for 120 cycles, then respawn pulse and round_number = 2.
- 2-0 match: P1 KOs twice -> game_over_condition = 1 after the second intermission, winner_p1 = 1, winner_p2 = 0; reset_gameplay -> IDLE, all outputs 0.
- Timeout: TICKS_PER_SEC = 2, ROUND_SECONDS = 2, healths 50/40, timer_enable held -> decision after 6 ticks, P1 wins; drop timer_enable for 5 cycles -> decision delayed by exactly 5.
- Double KO plus timeout in the same cycle -> draw, no win increments.
- MAX_ROUNDS = 3 with three draws -> MATCH_OVER after round 3, winner_p1 = winner_p2 = 0.
- Equal-health timeout: with ROUND_SUDDEN_DEATH_EN, round continues and a later p1_health = 0 gives P2 the round; without the macro, the result is draw.
